// File: rtl/softmax_prob_reader.sv
// Streams one completed row of the softermax probability buffer out as a valid/ready stream.
// Define SOFTMAX_PROB_READER_SAT_EN to saturate (rather than truncate) the reduced probability.
module softmax_prob_reader #(
    parameter  int LARGE_SIZE = 16,
    parameter  int ROW_WIDTH  = 64,
    parameter  int OUT_WIDTH  = 8,
    parameter  int SHIFT      = 8,
    localparam int AW         = $clog2(ROW_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  final_out_valid,
    output logic [AW-1:0]         read_addr,
    input  logic [LARGE_SIZE:0]   prob_buffer_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [AW-1:0]         out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [AW:0]   LAST_CNT  = (AW+1)'(ROW_WIDTH - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(ROW_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state;
    logic                 fov_q;
    logic [AW:0]          issue_cnt;
    logic                 inflight;

    logic                 head_valid;
    logic [OUT_WIDTH-1:0] head_data;
    logic [AW-1:0]        head_idx;
    logic                 head_last;
    logic                 tail_valid;
    logic [OUT_WIDTH-1:0] tail_data;
    logic [AW-1:0]        tail_idx;
    logic                 tail_last;

    logic                 start;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [1:0]           fifo_count;
    logic [1:0]           credit_used;
    logic [OUT_WIDTH-1:0] reduced;
    logic                 push_last;

    assign start = final_out_valid && !fov_q;
    assign pop   = head_valid && out_ready;
    assign push  = inflight;

    // A pop in the same cycle frees a slot, which is what sustains one element per cycle.
    assign fifo_count  = {1'b0, head_valid} + {1'b0, tail_valid};
    assign credit_used = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign issue       = (state == S_ISSUE) && (credit_used < 2'd2);

`ifdef SOFTMAX_PROB_READER_SAT_EN
    logic [LARGE_SIZE:0] shifted;
    assign shifted = prob_buffer_out >> SHIFT;
    assign reduced = (|(shifted >> OUT_WIDTH)) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];
`else
    assign reduced = OUT_WIDTH'(prob_buffer_out >> SHIFT);
`endif

    // read_addr still holds the address whose data is arriving this cycle.
    assign push_last = (read_addr == LAST_ADDR);

    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign out_index = head_idx;
    assign out_last  = head_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            fov_q     <= 1'b0;
            issue_cnt <= '0;
            read_addr <= '0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            fov_q    <= final_out_valid;
            inflight <= issue;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_ISSUE;
                        issue_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        read_addr <= issue_cnt[AW-1:0];
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == LAST_CNT) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Finish on the final handshake so done lands on the very next cycle.
                    if (pop && head_last && !inflight) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-entry skid FIFO; the head registers drive the stream outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_idx   <= '0;
            head_last  <= 1'b0;
            tail_valid <= 1'b0;
            tail_data  <= '0;
            tail_idx   <= '0;
            tail_last  <= 1'b0;
        end else if (pop) begin
            if (tail_valid) begin
                head_data <= tail_data;
                head_idx  <= tail_idx;
                head_last <= tail_last;
                if (push) begin
                    tail_data <= reduced;
                    tail_idx  <= read_addr;
                    tail_last <= push_last;
                end else begin
                    tail_valid <= 1'b0;
                end
            end else begin
                head_valid <= push;
                if (push) begin
                    head_data <= reduced;
                    head_idx  <= read_addr;
                    head_last <= push_last;
                end
            end
        end else if (push) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head_data  <= reduced;
                head_idx   <= read_addr;
                head_last  <= push_last;
            end else begin
                tail_valid <= 1'b1;
                tail_data  <= reduced;
                tail_idx   <= read_addr;
                tail_last  <= push_last;
            end
        end
    end

endmodule

// File: tb/tb_softmax_prob_reader.sv
// Self-checking bench for softmax_prob_reader: 8-entry row, reference model of shift/reduce
// and stream ordering, with randomized buffer contents and back-pressure.
module tb_softmax_prob_reader;

    localparam int LS = 16;
    localparam int RW = 8;
    localparam int OW = 8;
    localparam int SH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          final_out_valid;
    logic [2:0]    read_addr;
    logic [LS:0]   prob_buffer_out;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [2:0]    out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [LS:0]   mem [RW];

    int n_compared = 0;
    int n_mismatch = 0;

    int got_data[$];
    int got_idx[$];
    int got_last[$];
    int got_cyc[$];
    int done_cnt;
    int done_cyc;
    int busy_at_done;
    int stall_viol;

    always #5 clk = ~clk;

    // Registered read address, data visible in the cycle after it is issued.
    assign prob_buffer_out = mem[read_addr];

    softmax_prob_reader #(
        .LARGE_SIZE(LS),
        .ROW_WIDTH (RW),
        .OUT_WIDTH (OW),
        .SHIFT     (SH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .final_out_valid(final_out_valid),
        .read_addr      (read_addr),
        .prob_buffer_out(prob_buffer_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_index      (out_index),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    function automatic int model(input int v);
        int sh;
        sh = v / (1 << SH);
`ifdef SOFTMAX_PROB_READER_SAT_EN
        return (sh >= (1 << OW)) ? (1 << OW) - 1 : sh;
`else
        return sh % (1 << OW);
`endif
    endfunction

    // Starts a row with a fresh 0->1 edge and records every handshake. mode: 0 ready=1,
    // 1 ready every third cycle, 2 random ready, 3 ready low for the first 20 cycles.
    task automatic run_row(input int mode, input int second_edge);
        int pd;
        int pi;
        bit stalled;
        got_data.delete();
        got_idx.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_at_done = -1;
        stall_viol = 0;
        stalled = 1'b0;
        pd = 0;
        pi = 0;
        @(negedge clk);
        final_out_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        final_out_valid = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (second_edge >= 0 && cyc == second_edge - 1) final_out_valid = 1'b0;
            if (second_edge >= 0 && cyc == second_edge) final_out_valid = 1'b1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc % 3 == 0);
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc >= 20);
            endcase
            if (stalled && (!out_valid || int'(out_data) != pd || int'(out_index) != pi))
                stall_viol++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                busy_at_done = int'(busy);
            end
            if (out_valid && out_ready) begin
                got_data.push_back(int'(out_data));
                got_idx.push_back(int'(out_index));
                got_last.push_back(int'(out_last));
                got_cyc.push_back(cyc);
            end
            stalled = out_valid && !out_ready;
            pd = int'(out_data);
            pi = int'(out_index);
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        final_out_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < RW; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        n_compared++;
        if ({out_valid, out_last, busy, done} !== 4'b0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {out_valid, out_last, busy, done});
        end
        n_compared++;
        if ({read_addr, out_index, out_data} !== 14'd0) begin
            n_mismatch++;
            $display("[TB] FAIL reset_values: got addr %0d idx %0d data %0d expected 0 0 0",
                     read_addr, out_index, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < RW; i++) mem[i] = 17'(i * 256);
        run_row(0, -1);
        n_compared++;
        if (got_data.size() != RW) begin
            n_mismatch++;
            $display("[TB] FAIL basic_count: got %0d expected %0d", got_data.size(), RW);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_compared++;
            if (got_data[i] != i || got_idx[i] != i || got_last[i] != int'(i == RW - 1)) begin
                n_mismatch++;
                $display("[TB] FAIL basic_elem%0d: got data %0d idx %0d last %0d expected %0d %0d %0d",
                         i, got_data[i], got_idx[i], got_last[i], i, i, int'(i == RW - 1));
            end
            n_compared++;
            if (got_cyc[i] != 2 + i) begin
                n_mismatch++;
                $display("[TB] FAIL basic_timing%0d: got cycle %0d expected %0d", i, got_cyc[i], 2 + i);
            end
        end
        n_compared++;
        if (done_cnt != 1 || done_cyc != RW + 2 || busy_at_done != 0) begin
            n_mismatch++;
            $display("[TB] FAIL basic_done: got cnt %0d cyc %0d busy %0d expected 1 %0d 0",
                     done_cnt, done_cyc, busy_at_done, RW + 2);
        end
    endtask

    task automatic test_toggle_ready();
        for (int i = 0; i < RW; i++) mem[i] = 17'($urandom_range(0, 17'h1FFFF));
        run_row(1, -1);
        n_compared++;
        if (got_data.size() != RW || stall_viol != 0) begin
            n_mismatch++;
            $display("[TB] FAIL toggle_count: got %0d elems %0d stall errors expected %0d 0",
                     got_data.size(), stall_viol, RW);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_compared++;
            if (got_data[i] != model(int'(mem[i])) || got_idx[i] != i || got_last[i] != int'(i == RW - 1)) begin
                n_mismatch++;
                $display("[TB] FAIL toggle_elem%0d: got data %0d idx %0d last %0d expected %0d %0d %0d",
                         i, got_data[i], got_idx[i], got_last[i], model(int'(mem[i])), i, int'(i == RW - 1));
            end
        end
        n_compared++;
        if (got_cyc.size() == 0 || done_cnt != 1 || done_cyc != got_cyc[got_cyc.size() - 1] + 1) begin
            n_mismatch++;
            $display("[TB] FAIL toggle_done: got cnt %0d cyc %0d expected 1 pulse after last handshake",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_width_reduction();
        for (int i = 0; i < RW; i++) mem[i] = 17'($urandom_range(0, 17'h1FFFF));
        mem[3] = 17'h1FFFF;
        mem[5] = 17'h12345;
        run_row(2, -1);
        n_compared++;
        if (got_data.size() != RW) begin
            n_mismatch++;
            $display("[TB] FAIL width_count: got %0d expected %0d", got_data.size(), RW);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_compared++;
            if (got_data[i] != model(int'(mem[i])) || got_idx[i] != i) begin
                n_mismatch++;
                $display("[TB] FAIL width_elem%0d: got data %0d idx %0d expected %0d %0d",
                         i, got_data[i], got_idx[i], model(int'(mem[i])), i);
            end
        end
        n_compared++;
        if (got_data.size() != RW || got_data[3] != 'hFF) begin
            n_mismatch++;
            $display("[TB] FAIL width_idx3: got %0d expected 255", got_data.size() > 3 ? got_data[3] : -1);
        end
`ifdef SOFTMAX_PROB_READER_SAT_EN
        n_compared++;
        if (got_data.size() != RW || got_data[5] != 'hFF) begin
            n_mismatch++;
            $display("[TB] FAIL width_sat5: got %0d expected 255", got_data.size() > 5 ? got_data[5] : -1);
        end
`else
        n_compared++;
        if (got_data.size() != RW || got_data[5] != 'h23) begin
            n_mismatch++;
            $display("[TB] FAIL width_trunc5: got %0d expected 35", got_data.size() > 5 ? got_data[5] : -1);
        end
`endif
    endtask

    task automatic test_second_edge();
        int extra_valid;
        int extra_busy;
        for (int i = 0; i < RW; i++) mem[i] = 17'($urandom_range(0, 17'h1FFFF));
        run_row(0, 5);
        extra_valid = 0;
        extra_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) extra_valid++;
            if (busy || done) extra_busy++;
        end
        n_compared++;
        if (got_data.size() != RW || done_cnt != 1) begin
            n_mismatch++;
            $display("[TB] FAIL edge_one_row: got %0d elems %0d done expected %0d 1",
                     got_data.size(), done_cnt, RW);
        end
        for (int i = 0; i < got_idx.size(); i++) begin
            n_compared++;
            if (got_idx[i] != i || got_data[i] != model(int'(mem[i]))) begin
                n_mismatch++;
                $display("[TB] FAIL edge_elem%0d: got idx %0d data %0d expected %0d %0d",
                         i, got_idx[i], got_data[i], i, model(int'(mem[i])));
            end
        end
        n_compared++;
        if (extra_valid != 0 || extra_busy != 0) begin
            n_mismatch++;
            $display("[TB] FAIL edge_held_high: got %0d valid %0d busy cycles expected 0 0",
                     extra_valid, extra_busy);
        end
    endtask

    task automatic test_mid_reset();
        int hs;
        int bad;
        for (int i = 0; i < RW; i++) mem[i] = 17'($urandom_range(0, 17'h1FFFF));
        hs = 0;
        @(negedge clk);
        final_out_valid = 1'b0;
        @(negedge clk);
        final_out_valid = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            out_ready = (hs < 4);
            if (out_valid && out_ready) hs++;
            if (hs == 4 && !out_ready) break;
        end
        n_compared++;
        if (hs != 4 || !out_valid || out_index !== 3'd4) begin
            n_mismatch++;
            $display("[TB] FAIL midrst_setup: got %0d handshakes head %0d expected 4 4", hs, out_index);
        end
        rst = 1'b1;
        final_out_valid = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_mismatch++;
            $display("[TB] FAIL midrst_clear: got valid/busy/done %b expected 000", {out_valid, busy, done});
        end
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid || busy || done) bad++;
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatch++;
            $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", bad);
        end
        run_row(0, -1);
        n_compared++;
        if (got_idx.size() != RW || done_cnt != 1) begin
            n_mismatch++;
            $display("[TB] FAIL midrst_restart: got %0d elems %0d done expected %0d 1",
                     got_idx.size(), done_cnt, RW);
        end
        for (int i = 0; i < got_idx.size(); i++) begin
            n_compared++;
            if (got_idx[i] != i || got_data[i] != model(int'(mem[i])) || got_cyc[i] != 2 + i) begin
                n_mismatch++;
                $display("[TB] FAIL midrst_elem%0d: got idx %0d data %0d cyc %0d expected %0d %0d %0d",
                         i, got_idx[i], got_data[i], got_cyc[i], i, model(int'(mem[i])), 2 + i);
            end
        end
    endtask

    task automatic test_long_stall();
        for (int i = 0; i < RW; i++) mem[i] = 17'($urandom_range(0, 17'h1FFFF));
        run_row(3, -1);
        n_compared++;
        if (got_idx.size() != RW || stall_viol != 0 || done_cnt != 1) begin
            n_mismatch++;
            $display("[TB] FAIL stall_summary: got %0d elems %0d stall errors %0d done expected %0d 0 1",
                     got_idx.size(), stall_viol, done_cnt, RW);
        end
        for (int i = 0; i < got_idx.size(); i++) begin
            n_compared++;
            if (got_idx[i] != i || got_data[i] != model(int'(mem[i])) || got_cyc[i] != 20 + i) begin
                n_mismatch++;
                $display("[TB] FAIL stall_elem%0d: got idx %0d data %0d cyc %0d expected %0d %0d %0d",
                         i, got_idx[i], got_data[i], got_cyc[i], i, model(int'(mem[i])), 20 + i);
            end
        end
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < RW; i++) mem[i] = 17'($urandom_range(0, 17'h1FFFF));
            run_row(2, -1);
            n_compared++;
            if (got_idx.size() != RW || stall_viol != 0 || done_cnt != 1) begin
                n_mismatch++;
                $display("[TB] FAIL rand%0d_summary: got %0d elems %0d stall errors %0d done expected %0d 0 1",
                         r, got_idx.size(), stall_viol, done_cnt, RW);
            end
            for (int i = 0; i < got_idx.size(); i++) begin
                n_compared++;
                if (got_idx[i] != i || got_data[i] != model(int'(mem[i])) || got_last[i] != int'(i == RW - 1)) begin
                    n_mismatch++;
                    $display("[TB] FAIL rand%0d_elem%0d: got idx %0d data %0d last %0d expected %0d %0d %0d",
                             r, i, got_idx[i], got_data[i], got_last[i], i, model(int'(mem[i])), int'(i == RW - 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_ready();
        test_width_reduction();
        test_second_edge();
        test_mid_reset();
        test_long_stall();
        test_random_rows();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
